// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every non-clock signal of mem_port_arbiter: the MEM-stage request
//   and response, the debug/DMA request and response, and the data-memory port.
//   modport master : the arbiter's view (drives memory, stall/done, responses).
//   modport slave  : the surrounding pipeline / debug unit / memory view.
// Parameters: ADDR_W address width, DATA_W data width.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // MEM stage
  logic              pipe_req_rd;
  logic              pipe_req_wr;
  logic              pipe_mop_en;
  logic [ADDR_W-1:0] pipe_addr;
  logic [ADDR_W-1:0] pipe_addr2;
  logic [DATA_W-1:0] pipe_wdata;
  logic [2:0]        pipe_func3;
  logic              pipe_stall;
  logic              pipe_done;
  logic [DATA_W-1:0] pipe_rdata;
  logic [DATA_W-1:0] pipe_rdata2;
  // debug / DMA
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    input  pipe_req_rd, pipe_req_wr, pipe_mop_en, pipe_addr, pipe_addr2,
           pipe_wdata, pipe_func3,
    output pipe_stall, pipe_done, pipe_rdata, pipe_rdata2,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_func3, mem_err,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output pipe_req_rd, pipe_req_wr, pipe_mop_en, pipe_addr, pipe_addr2,
           pipe_wdata, pipe_func3,
    input  pipe_stall, pipe_done, pipe_rdata, pipe_rdata2,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_func3, mem_err,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between the MEM stage and a debug/DMA
//   requester. The MEM stage may issue one access or a two-address op (mop,
//   addr then addr2, never split by debug). pipe_stall holds EX/MEM until the
//   pipe_done pulse. Debug normally loses to the pipe but wins once it has been
//   passed over STARVE_LIMIT times in a row.
// Ports: clk, rst (async, active low), bus (mem_port_arbiter_if.master).
// Optional: define MEM_TIMEOUT_EN to abort accesses that see TIMEOUT_CYC
//   consecutive wait cycles (read data forced to all ones, sticky mem_err).
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master bus
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, PIPE_A, PIPE_B, DBG, P_DONE, D_DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, addr2_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        func3_q;
  logic              we_q, mop_q;
  logic              mem_req_q, pipe_done_q, dbg_gnt_q, dbg_done_q;
  logic [DATA_W-1:0] prd_q, prd2_q, drd_q;
  logic [3:0]        starve_q;

  logic              pipe_req, dbg_win, acc_end, acc_abort;
  logic [DATA_W-1:0] acc_data;

  assign pipe_req = bus.pipe_req_rd | bus.pipe_req_wr;
  assign dbg_win  = bus.dbg_req & (~pipe_req | (starve_q == 4'(STARVE_LIMIT)));

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_q;
  logic          mem_err_q;

  // Counts consecutive wait cycles of the access currently on the port.
  assign acc_abort = mem_req_q & ~bus.mem_ready & (wait_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (!mem_req_q || bus.mem_ready || acc_abort) wait_q <= '0;
      else                                          wait_q <= wait_q + 1'b1;
      if (acc_abort) mem_err_q <= 1'b1;
    end
  end
  assign bus.mem_err = mem_err_q;
`else
  assign acc_abort   = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  assign acc_end  = (mem_req_q & bus.mem_ready) | acc_abort;
  assign acc_data = acc_abort ? {DATA_W{1'b1}} : bus.mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr2_q     <= '0;
      wdata_q     <= '0;
      func3_q     <= '0;
      we_q        <= 1'b0;
      mop_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      pipe_done_q <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      dbg_done_q  <= 1'b0;
      prd_q       <= '0;
      prd2_q      <= '0;
      drd_q       <= '0;
      starve_q    <= '0;
    end else begin
      pipe_done_q <= 1'b0;
      dbg_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dbg_win) begin
            state_q   <= DBG;
            mem_req_q <= 1'b1;
            dbg_gnt_q <= 1'b1;
            addr_q    <= bus.dbg_addr;
            wdata_q   <= bus.dbg_wdata;
            we_q      <= bus.dbg_we;
            func3_q   <= 3'b010;  // debug always moves whole words
            mop_q     <= 1'b0;
            starve_q  <= '0;
          end else if (pipe_req) begin
            state_q   <= PIPE_A;
            mem_req_q <= 1'b1;
            addr_q    <= bus.pipe_addr;
            addr2_q   <= bus.pipe_addr2;
            wdata_q   <= bus.pipe_wdata;
            we_q      <= bus.pipe_req_wr;  // store wins over load
            func3_q   <= bus.pipe_func3;
            mop_q     <= bus.pipe_mop_en;
            if (bus.dbg_req && starve_q != 4'(STARVE_LIMIT)) starve_q <= starve_q + 4'd1;
          end
        end
        PIPE_A: if (acc_end) begin
          if (!we_q) prd_q <= acc_data;
          if (mop_q) begin
            // second half reuses the live address register; mem_req stays up
            state_q <= PIPE_B;
            addr_q  <= addr2_q;
          end else begin
            state_q     <= P_DONE;
            mem_req_q   <= 1'b0;
            pipe_done_q <= 1'b1;
          end
        end
        PIPE_B: if (acc_end) begin
          if (!we_q) prd2_q <= acc_data;
          state_q     <= P_DONE;
          mem_req_q   <= 1'b0;
          pipe_done_q <= 1'b1;
        end
        DBG: if (acc_end) begin
          if (!we_q) drd_q <= acc_data;
          state_q    <= D_DONE;
          mem_req_q  <= 1'b0;
          dbg_gnt_q  <= 1'b0;
          dbg_done_q <= 1'b1;
        end
        P_DONE:  state_q <= IDLE;
        D_DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pipe_stall  = pipe_req & ~pipe_done_q;
  assign bus.pipe_done   = pipe_done_q;
  assign bus.pipe_rdata  = prd_q;
  assign bus.pipe_rdata2 = prd2_q;
  assign bus.dbg_gnt     = dbg_gnt_q;
  assign bus.dbg_done    = dbg_done_q;
  assign bus.dbg_rdata   = drd_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_func3   = func3_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single data-memory port between the MEM stage and a debug/DMA requester.
- The MEM-stage request comes straight from the EX/MEM register: read/write, address, optional second address for a dual-address memory op (mop), store data and func3.
- Drives pipe_stall to hold the EX/MEM register while an access is in flight.
- Runs a req/ready handshake to memory and applies starvation-bounded priority between the two requesters.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive pipe grants while dbg_req is pending before debug is forced to win. Legal range 1..15.
- TIMEOUT_CYC, 64, wait-cycle limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- pipe_req_rd  in  1  MEM-stage load.
- pipe_req_wr  in  1  MEM-stage store; wins if both read and write are high.
- pipe_mop_en  in  1  two accesses: pipe_addr, then pipe_addr2.
- pipe_addr  in  ADDR_W  first address.
- pipe_addr2  in  ADDR_W  second address.
- pipe_wdata  in  DATA_W  store data, used for both mop accesses.
- pipe_func3  in  3  access size/sign, forwarded to memory.
- pipe_stall  out  1  hold the EX/MEM register.
- pipe_done  out  1  one-cycle completion pulse.
- pipe_rdata  out  DATA_W  data from first access.
- pipe_rdata2  out  DATA_W  data from second access.
- dbg_req  in  1  debug request, level, held until dbg_done.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  high while the debug access owns the port.
- dbg_done  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  debug read data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_func3  out  3  access size/sign to memory.
- mem_ready  in  1  access completes in a cycle with mem_req=1 and mem_ready=1; mem_rdata is valid in that cycle.
- mem_rdata  in  DATA_W  memory read data.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is asynchronous, active-low.
- Reset values: all registered outputs 0, FSM=IDLE, starve counter 0, mem_err 0. Reset mid-access drops mem_req immediately and discards the access.
- FSM states: IDLE, PIPE_A, PIPE_B, DBG, P_DONE, D_DONE.
- IDLE, candidates: pipe_req = pipe_req_rd|pipe_req_wr; debug = dbg_req.
- IDLE, arbitration: pipe wins unless dbg_req=1 and starve_cnt==STARVE_LIMIT.
  - Grant to pipe latches addr/addr2/wdata/func3/we/mop → PIPE_A. starve_cnt+1 (saturating) if dbg_req=1.
  - Grant to debug → DBG, starve_cnt cleared.
- mem_req is asserted only in PIPE_A, PIPE_B and DBG. mem_* come from registered/latched values and stay stable until mem_ready.
- PIPE_A, on mem_ready: pipe_rdata ← mem_rdata (reads only). Then → PIPE_B if mop, else → P_DONE.
- PIPE_B, on mem_ready: pipe_rdata2 ← mem_rdata → P_DONE.
- A mop is atomic; debug never interleaves between A and B.
- P_DONE: pipe_done=1 for exactly one cycle → IDLE.
- DBG: dbg_gnt=1. On mem_ready: dbg_rdata ← mem_rdata → D_DONE (dbg_done=1 for one cycle) → IDLE.
- pipe_stall = pipe_req & ~pipe_done (combinational). Read data is valid in the pipe_done cycle and held until the next pipe read completes.
- Latency with mem_ready tied 1:
  - Single access: grant at cycle 0, mem_req at cycle 1, pipe_done at cycle 2 (2 stall cycles).
  - Mop: pipe_done at cycle 3.
  - Each wait cycle adds 1.
- Write data: pipe_rdata/pipe_rdata2 unchanged on writes; a single access leaves pipe_rdata2 unchanged.
- Simultaneous requests in IDLE: resolved as above.
- A request dropping while not in IDLE is ignored; the latched access completes.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Per-access counter of cycles with mem_req=1 and mem_ready=0.
  - On reaching TIMEOUT_CYC, abort the access: move to the next state as if completed, read data := {DATA_W{1'b1}}.
  - mem_err set, sticky until reset.
- Undefined: waits indefinitely; mem_err tied 0.

Test Plan:
- Pipe load addr 0x100, mem_ready=1, rdata 0xA5A5_0001 → mem_req cycle 1, pipe_done cycle 2, pipe_rdata=0xA5A5_0001, pipe_stall high cycles 0-1.
- Mop store addr 0x200/0x204, wdata 0x1234 → two mem_we accesses, in order, same data; pipe_done cycle 3.
- mem_ready delayed 3 cycles on a load → mem_addr stable throughout, pipe_done 3 cycles later.
- Pipe and dbg_req continuously high, STARVE_LIMIT=4 → 4 pipe grants, then 1 debug grant, counter cleared; dbg never splits a mop.
- rst low while in PIPE_B → mem_req low immediately; all outputs 0; clean restart.
- With MEM_TIMEOUT_EN, mem_ready never high → abort after 64 cycles, pipe_rdata=0xFFFF_FFFF, mem_err=1 until reset.
